// File: rtl/api_out_arbiter_pkg.sv
// Shared types and helpers for the outbound API message arbiter.
// Holds the FSM state encoding and the header/pointer width helpers.
package api_out_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  localparam int STAT_W = 32;

  function automatic int hdr_width(input int slot_w, input int fpga_w,
                                   input int reg_w, input int cmd_w);
    return slot_w + fpga_w + 2 * reg_w + 2 * cmd_w;
  endfunction

  function automatic int ptr_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/api_rr_picker.sv
// Combinational round-robin picker: one-hot grant of the first valid
// requester found searching upward from ptr+1, wrapping modulo NUM_REQ.
module api_rr_picker
  import api_out_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int PTR_W = ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  always_comb begin
    int   idx;
    logic found;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/api_out_arbiter.sv
// Round-robin arbiter with message locking onto the outbound API port.
// Optional per-requester beat counters are built when API_ARB_STATS_EN is defined.
module api_out_arbiter
  import api_out_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int SLOT_W  = 5,
  parameter int FPGA_W  = 4,
  parameter int REG_W   = 16,
  parameter int CMD_W   = 8,
  parameter int DATA_W  = 64,
  localparam int HDR_W  = hdr_width(SLOT_W, FPGA_W, REG_W, CMD_W)
) (
  input  logic                        api_clk_in,
  input  logic                        api_rst_n_in,
  input  logic [NUM_REQ-1:0]          req_valid_in,
  input  logic [NUM_REQ-1:0]          req_last_in,
  input  logic [NUM_REQ*HDR_W-1:0]    req_hdr_in,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data_in,
  output logic [NUM_REQ-1:0]          req_ready_out,
  input  logic                        api_o_rfd_in,
  output logic [SLOT_W-1:0]           api_o_tgt_slot_out,
  output logic [FPGA_W-1:0]           api_o_tgt_fpga_out,
  output logic [REG_W-1:0]            api_o_tgt_reg_out,
  output logic [CMD_W-1:0]            api_o_tgt_cmd_out,
  output logic [REG_W-1:0]            api_o_src_reg_out,
  output logic [CMD_W-1:0]            api_o_src_cmd_out,
  output logic [DATA_W-1:0]           api_o_data_out,
  output logic                        api_o_wr_en_out,
  output logic [NUM_REQ-1:0]          grant_out,
  input  logic                        stat_clr_in,
  output logic [NUM_REQ*STAT_W-1:0]   stat_beats_out
);

  localparam int PTR_W        = ptr_width(NUM_REQ);
  // Header packing, LSB first: src_cmd, src_reg, tgt_cmd, tgt_reg, tgt_fpga, tgt_slot.
  localparam int OFS_SRC_CMD  = 0;
  localparam int OFS_SRC_REG  = CMD_W;
  localparam int OFS_TGT_CMD  = CMD_W + REG_W;
  localparam int OFS_TGT_REG  = 2 * CMD_W + REG_W;
  localparam int OFS_TGT_FPGA = 2 * CMD_W + 2 * REG_W;
  localparam int OFS_TGT_SLOT = OFS_TGT_FPGA + FPGA_W;

  arb_state_e          state, state_nxt;
  logic [PTR_W-1:0]    ptr, ptr_nxt, owner_idx;
  logic [NUM_REQ-1:0]  grant, grant_nxt, pick, ready, fire_vec;
  logic                fire, fire_last;
  logic [HDR_W-1:0]    sel_hdr;
  logic [DATA_W-1:0]   sel_data;
  logic [HDR_W-1:0]    hdr_p1;
  logic [DATA_W-1:0]   data_p1;
  logic                vld_p1;

  api_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .valid (req_valid_in),
    .ptr   (ptr),
    .grant (pick)
  );

  assign ready         = (state == ST_BUSY) ? (grant & {NUM_REQ{api_o_rfd_in}}) : '0;
  assign fire_vec      = req_valid_in & ready;
  assign fire          = |fire_vec;
  assign fire_last     = |(fire_vec & req_last_in);
  assign req_ready_out = ready;
  assign grant_out     = grant;

  always_comb begin
    owner_idx = '0;
    sel_hdr   = '0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        owner_idx = PTR_W'(i);
        sel_hdr   = req_hdr_in[i*HDR_W +: HDR_W];
        sel_data  = req_data_in[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    ptr_nxt   = ptr;
    case (state)
      ST_IDLE: begin
        if (|req_valid_in) begin
          grant_nxt = pick;
          state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // The grant is held until the owner's last beat, even if its valid drops.
        if (fire_last) begin
          ptr_nxt   = owner_idx;
          grant_nxt = '0;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge api_clk_in or negedge api_rst_n_in) begin
    if (!api_rst_n_in) begin
      state <= ST_IDLE;
      grant <= '0;
      ptr   <= PTR_W'(NUM_REQ - 1);
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Stage p1: registered API write bundle.
  always_ff @(posedge api_clk_in or negedge api_rst_n_in) begin
    if (!api_rst_n_in) begin
      vld_p1  <= 1'b0;
      hdr_p1  <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= fire;
      if (fire) begin
        hdr_p1  <= sel_hdr;
        data_p1 <= sel_data;
      end
    end
  end

  assign api_o_wr_en_out    = vld_p1;
  assign api_o_data_out     = data_p1;
  assign api_o_tgt_slot_out = hdr_p1[OFS_TGT_SLOT +: SLOT_W];
  assign api_o_tgt_fpga_out = hdr_p1[OFS_TGT_FPGA +: FPGA_W];
  assign api_o_tgt_reg_out  = hdr_p1[OFS_TGT_REG  +: REG_W];
  assign api_o_tgt_cmd_out  = hdr_p1[OFS_TGT_CMD  +: CMD_W];
  assign api_o_src_reg_out  = hdr_p1[OFS_SRC_REG  +: REG_W];
  assign api_o_src_cmd_out  = hdr_p1[OFS_SRC_CMD  +: CMD_W];

`ifdef API_ARB_STATS_EN
  logic [STAT_W-1:0] stat_cnt [NUM_REQ];

  // Clear has priority over a same-cycle increment; counters wrap naturally.
  always_ff @(posedge api_clk_in or negedge api_rst_n_in) begin
    if (!api_rst_n_in) begin
      for (int i = 0; i < NUM_REQ; i++) stat_cnt[i] <= '0;
    end else if (stat_clr_in) begin
      for (int i = 0; i < NUM_REQ; i++) stat_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (fire_vec[i]) stat_cnt[i] <= stat_cnt[i] + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    assign stat_beats_out[g*STAT_W +: STAT_W] = stat_cnt[g];
  end
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr_in;
  assign stat_beats_out  = '0;
`endif

endmodule

// File: tb/tb_api_out_arbiter.sv
// Directed self-checking bench for api_out_arbiter (4 requesters, default widths).
// Statistics expectations follow API_ARB_STATS_EN as seen by this compile.
module tb_api_out_arbiter;

  localparam int N  = 4;
  localparam int HW = 57;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_last, req_ready;
  logic [N*HW-1:0] req_hdr;
  logic [N*DW-1:0] req_data;
  logic            rfd;
  logic [4:0]      tgt_slot;
  logic [3:0]      tgt_fpga;
  logic [15:0]     tgt_reg, src_reg;
  logic [7:0]      tgt_cmd, src_cmd;
  logic [63:0]     wr_data;
  logic            wr_en;
  logic [N-1:0]    grant;
  logic            stat_clr;
  logic [N*32-1:0] stat_beats;

  int total = 0;
  int bad   = 0;

  int       nbeats [N];
  int       beat   [N];
  logic [N-1:0] stall;
  logic [N-1:0] fire_prev;
  logic     rfd_v, clr_v;
  logic     obs_wr;
  logic [63:0] obs_data;

`ifdef API_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  api_out_arbiter #(.NUM_REQ(N)) dut (
    .api_clk_in         (clk),
    .api_rst_n_in       (rst_n),
    .req_valid_in       (req_valid),
    .req_last_in        (req_last),
    .req_hdr_in         (req_hdr),
    .req_data_in        (req_data),
    .req_ready_out      (req_ready),
    .api_o_rfd_in       (rfd),
    .api_o_tgt_slot_out (tgt_slot),
    .api_o_tgt_fpga_out (tgt_fpga),
    .api_o_tgt_reg_out  (tgt_reg),
    .api_o_tgt_cmd_out  (tgt_cmd),
    .api_o_src_reg_out  (src_reg),
    .api_o_src_cmd_out  (src_cmd),
    .api_o_data_out     (wr_data),
    .api_o_wr_en_out    (wr_en),
    .grant_out          (grant),
    .stat_clr_in        (stat_clr),
    .stat_beats_out     (stat_beats)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [HW-1:0] hdr_of(input int i);
    return {5'(i + 1), 4'(i), 16'(16'h1000 + i), 8'(8'h10 + i), 16'(16'h2000 + i), 8'(8'h20 + i)};
  endfunction

  function automatic logic [63:0] data_of(input int i, input int b);
    return 64'hD000_0000_0000_0000 | 64'(i * 256 + b);
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]           = (beat[i] < nbeats[i]) && !stall[i];
      req_last[i]            = (beat[i] == nbeats[i] - 1);
      req_hdr[i*HW +: HW]    = hdr_of(i);
      req_data[i*DW +: DW]   = data_of(i, beat[i]);
    end
    rfd      = rfd_v;
    stat_clr = clr_v;
  endtask

  task automatic start();
    drive();
    #1;
    fire_prev = req_valid & req_ready;
  endtask

  // One clock of the requester model: observe the write, advance beats that fired, redrive.
  task automatic cycle();
    @(posedge clk);
    #1;
    obs_wr   = wr_en;
    obs_data = wr_data;
    for (int i = 0; i < N; i++) if (fire_prev[i]) beat[i]++;
    drive();
    #1;
    fire_prev = req_valid & req_ready;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      nbeats[i] = 0;
      beat[i]   = 0;
    end
    stall     = '0;
    rfd_v     = 1'b1;
    clr_v     = 1'b0;
    fire_prev = '0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL reset_grant: got %b want 0000", grant); end
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    total++; if ({tgt_slot, tgt_fpga, tgt_reg, tgt_cmd, src_reg, src_cmd, wr_data} !== '0) begin
      bad++; $display("FAIL reset_bundle: got data %h slot %h want all zero", wr_data, tgt_slot);
    end
    total++; if (stat_beats !== '0) begin bad++; $display("FAIL reset_stats: got %h want 0", stat_beats); end
  endtask

  task automatic test_single_beat();
    do_reset();
    req_valid = 4'b0001;
    req_last  = 4'b0001;
    req_data[63:0] = 64'hA5A5;
    rfd = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL single_idle_ready: got %b want 0000", req_ready); end
    @(posedge clk); #1;
    total++; if (grant !== 4'b0001) begin bad++; $display("FAIL single_grant: got %b want 0001", grant); end
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL single_early_wr: got %b want 0", wr_en); end
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_ready: got %b want 0001", req_ready); end
    @(posedge clk); #1;
    total++; if (wr_en !== 1'b1 || wr_data !== 64'hA5A5) begin
      bad++; $display("FAIL single_write: got wr %b data %h want 1 a5a5", wr_en, wr_data);
    end
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL single_release: got %b want 0000", grant); end
    req_valid = 4'b0000;
    req_last  = 4'b0000;
    repeat (3) begin
      @(posedge clk); #1;
      total++; if (wr_en !== 1'b0 || grant !== 4'b0000) begin
        bad++; $display("FAIL single_quiet: got wr %b grant %b want 0 0000", wr_en, grant);
      end
    end
  endtask

  task automatic test_round_robin();
    int n = 0;
    int first = 0;
    do_reset();
    for (int i = 0; i < N; i++) nbeats[i] = 2;
    start();
    for (int c = 0; c < 60 && n < 8; c++) begin
      cycle();
      if (obs_wr) begin
        if (n == 0) first = c;
        total++; if (obs_data !== data_of(n / 2, n % 2)) begin
          bad++; $display("FAIL rr_order_%0d: got %h want %h", n, obs_data, data_of(n / 2, n % 2));
        end
        total++; if (c - first !== (n / 2) * 3 + n % 2) begin
          bad++; $display("FAIL rr_spacing_%0d: got offset %0d want %0d", n, c - first, (n / 2) * 3 + n % 2);
        end
        if (n == 4) begin
          total++; if (tgt_slot !== 5'd3 || tgt_fpga !== 4'd2 || tgt_reg !== 16'h1002 ||
                       tgt_cmd !== 8'h12 || src_reg !== 16'h2002 || src_cmd !== 8'h22) begin
            bad++; $display("FAIL rr_header: got %h %h %h %h %h %h want 03 2 1002 12 2002 22",
                            tgt_slot, tgt_fpga, tgt_reg, tgt_cmd, src_reg, src_cmd);
          end
        end
        n++;
      end
    end
    total++; if (n !== 8) begin bad++; $display("FAIL rr_count: got %0d writes want 8", n); end
    repeat (3) begin
      cycle();
      total++; if (obs_wr !== 1'b0) begin bad++; $display("FAIL rr_extra_write: got %b want 0", obs_wr); end
    end
  endtask

  task automatic test_backpressure();
    bit hit = 0;
    do_reset();
    nbeats[2] = 2;
    start();
    for (int c = 0; c < 10 && !hit; c++) begin
      cycle();
      if (fire_prev[2]) hit = 1;
    end
    total++; if (!hit) begin bad++; $display("FAIL bp_first_fire: got no fire want fire of r2 beat 0"); end
    rfd_v = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      if (k == 0) begin
        total++; if (obs_wr !== 1'b1 || obs_data !== data_of(2, 0)) begin
          bad++; $display("FAIL bp_beat0: got wr %b data %h want 1 %h", obs_wr, obs_data, data_of(2, 0));
        end
      end else begin
        total++; if (obs_wr !== 1'b0) begin bad++; $display("FAIL bp_stall_wr_%0d: got %b want 0", k, obs_wr); end
      end
      total++; if (req_ready !== 4'b0000 || grant !== 4'b0100) begin
        bad++; $display("FAIL bp_hold_%0d: got ready %b grant %b want 0000 0100", k, req_ready, grant);
      end
    end
    rfd_v = 1'b1;
    cycle();
    total++; if (obs_wr !== 1'b0 || req_ready !== 4'b0100) begin
      bad++; $display("FAIL bp_resume: got wr %b ready %b want 0 0100", obs_wr, req_ready);
    end
    cycle();
    total++; if (obs_wr !== 1'b1 || obs_data !== data_of(2, 1) || grant !== 4'b0000) begin
      bad++; $display("FAIL bp_beat1: got wr %b data %h grant %b want 1 %h 0000", obs_wr, obs_data, grant, data_of(2, 1));
    end
  endtask

  task automatic test_owner_stall();
    int n = 0;
    logic [63:0] exp_seq [3];
    exp_seq[0] = data_of(0, 1);
    exp_seq[1] = data_of(0, 2);
    exp_seq[2] = data_of(1, 0);
    do_reset();
    nbeats[0] = 3;
    nbeats[1] = 1;
    start();
    cycle();
    total++; if (grant !== 4'b0001 || fire_prev !== 4'b0001) begin
      bad++; $display("FAIL stall_first: got grant %b fire %b want 0001 0001", grant, fire_prev);
    end
    stall[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      total++; if (grant !== 4'b0001 || req_ready[1] !== 1'b0) begin
        bad++; $display("FAIL stall_hold_%0d: got grant %b ready %b want 0001 r1=0", k, grant, req_ready);
      end
      total++; if (obs_wr !== (k == 0)) begin
        bad++; $display("FAIL stall_wr_%0d: got %b want %b", k, obs_wr, k == 0);
      end
    end
    stall[0] = 1'b0;
    for (int c = 0; c < 20; c++) begin
      cycle();
      if (obs_wr) begin
        total++; if (n > 2 || obs_data !== exp_seq[n]) begin
          bad++; $display("FAIL stall_order_%0d: got %h want %h", n, obs_data, exp_seq[n % 3]);
        end
        n++;
      end
    end
    total++; if (n !== 3) begin bad++; $display("FAIL stall_count: got %0d writes want 3", n); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    nbeats[0] = 3;
    nbeats[1] = 2;
    start();
    cycle();
    cycle();
    total++; if (obs_wr !== 1'b1 || grant !== 4'b0001) begin
      bad++; $display("FAIL rmid_setup: got wr %b grant %b want 1 0001", obs_wr, grant);
    end
    rst_n = 1'b0;
    #1;
    fire_prev = '0;
    total++; if (wr_en !== 1'b0 || grant !== 4'b0000 || req_ready !== 4'b0000 || wr_data !== 64'h0 ||
                 tgt_slot !== 5'd0 || src_cmd !== 8'h0) begin
      bad++; $display("FAIL rmid_clear: got wr %b grant %b ready %b data %h want all zero", wr_en, grant, req_ready, wr_data);
    end
    for (int i = 0; i < N; i++) beat[i] = 0;
    drive();
    repeat (2) begin
      @(posedge clk); #1;
      total++; if (wr_en !== 1'b0 || grant !== 4'b0000) begin
        bad++; $display("FAIL rmid_held: got wr %b grant %b want 0 0000", wr_en, grant);
      end
    end
    rst_n = 1'b1;
    cycle();
    total++; if (grant !== 4'b0001) begin bad++; $display("FAIL rmid_regrant: got %b want 0001", grant); end
  endtask

  task automatic test_stats();
    do_reset();
    nbeats[3] = 10;
    start();
    for (int c = 0; c < 40; c++) cycle();
    total++; if (stat_beats[96 +: 32] !== (STATS ? 32'd10 : 32'd0)) begin
      bad++; $display("FAIL stat_count10: got %0d want %0d", stat_beats[96 +: 32], STATS ? 10 : 0);
    end
    total++; if (stat_beats[0 +: 96] !== 96'h0) begin
      bad++; $display("FAIL stat_others: got %h want 0", stat_beats[0 +: 96]);
    end
    nbeats[3] = 11;
    start();
    clr_v = 1'b1;
    cycle();
    clr_v = 1'b0;
    cycle();
    total++; if (obs_wr !== 1'b1 || stat_beats[96 +: 32] !== 32'd0) begin
      bad++; $display("FAIL stat_clear_wins: got wr %b count %0d want 1 0", obs_wr, stat_beats[96 +: 32]);
    end
    nbeats[3] = 12;
    start();
    repeat (4) cycle();
    total++; if (stat_beats[96 +: 32] !== (STATS ? 32'd1 : 32'd0)) begin
      bad++; $display("FAIL stat_after_clear: got %0d want %0d", stat_beats[96 +: 32], STATS ? 1 : 0);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_hdr   = '0;
    req_data  = '0;
    rfd       = 1'b1;
    stat_clr  = 1'b0;
    test_reset();
    test_single_beat();
    test_round_robin();
    test_backpressure();
    test_owner_stall();
    test_reset_mid();
    test_stats();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
